instr_fetch: RTL and testbench

//  Fetch stage feeding the control unit (CU): holds the PC and the instruction memory, and streams
//  {pc, instr} to the CU over a valid/ready handshake. Accepts branch/jump redirects and halt from
//  the CU. A 1-entry skid buffer absorbs the in-flight synchronous read when the CU stalls.

---
 rtl/instr_fetch.sv | 135 +++++++++++++
 tb/tb_instr_fetch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: PC, instruction memory and a 2-slot (output + skid) delivery path to the CU.
// Reads are synchronous; each issued word lands in the output register or the skid at the issuing edge.
module instr_fetch #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned IMEM_DEPTH = 256,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter string       INIT_FILE  = "",
    localparam int unsigned AW        = $clog2(IMEM_DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            imem_we,
    input  logic [AW-1:0]   imem_waddr,
    input  logic [XLEN-1:0] imem_wdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            cu_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt_req,
    output logic            halted,
    output logic            fault,
    output logic [31:0]     fetch_count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED, S_FAULT} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] mem [IMEM_DEPTH];

    logic [XLEN-1:0] pc_q;
    logic            out_valid_q, sk_valid_q, bubble_q, halted_q, fault_q;
    logic [XLEN-1:0] out_instr_q, out_pc_q, sk_instr_q, sk_pc_q;
    logic [31:0]     count_q;

    logic            xfer, pc_bad, want_issue, issue, fault_hit, in_run;
    logic [1:0]      occ_after;
    logic [AW-1:0]   rd_idx;

    // Issue decision: a slot must be free once this edge's transfer is accounted for.
    always_comb begin
        in_run     = (state_q == S_RUN);
        xfer       = out_valid_q & cu_ready;
        occ_after  = 2'(out_valid_q) + 2'(sk_valid_q) - 2'(xfer);
        pc_bad     = (pc_q[1:0] != 2'b00) || ((pc_q >> 2) >= XLEN'(IMEM_DEPTH));
        rd_idx     = pc_q[AW+1:2];
        want_issue = in_run && !redirect_valid && !halt_req && !bubble_q && (occ_after != 2'd2);
        issue      = want_issue && !pc_bad;
        fault_hit  = want_issue && pc_bad;

        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = S_RUN;
            S_RUN: begin
                if (redirect_valid)  state_d = S_RUN;
                else if (halt_req)   state_d = S_HALTED;
                else if (fault_hit)  state_d = S_FAULT;
            end
            S_HALTED: state_d = S_HALTED;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Preload port; contents survive reset.
    always_ff @(posedge clk) begin
        if (imem_we) mem[imem_waddr] <= imem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            sk_valid_q  <= 1'b0;
            sk_instr_q  <= '0;
            sk_pc_q     <= '0;
            bubble_q    <= 1'b0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            if (xfer) count_q <= count_q + 32'd1;
            // One dead cycle after a redirect before the target is read.
            bubble_q <= in_run && redirect_valid;
            halted_q <= (state_d == S_HALTED);
            fault_q  <= (state_d == S_FAULT);

            if (in_run && redirect_valid) begin
                pc_q        <= redirect_pc;
                out_valid_q <= 1'b0;
                sk_valid_q  <= 1'b0;
            end else if (in_run && (halt_req || fault_hit)) begin
                out_valid_q <= 1'b0;
                sk_valid_q  <= 1'b0;
            end else begin
                if (xfer) begin
                    out_valid_q <= sk_valid_q;
                    sk_valid_q  <= 1'b0;
                    if (sk_valid_q) begin
                        out_instr_q <= sk_instr_q;
                        out_pc_q    <= sk_pc_q;
                    end
                end
                if (issue) begin
                    pc_q <= pc_q + XLEN'(4);
                    if (occ_after == 2'd0) begin
                        out_valid_q <= 1'b1;
                        out_instr_q <= mem[rd_idx];
                        out_pc_q    <= pc_q;
                    end else begin
                        sk_valid_q  <= 1'b1;
                        sk_instr_q  <= mem[rd_idx];
                        sk_pc_q     <= pc_q;
                    end
                end
            end
        end
    end

    assign if_valid    = out_valid_q;
    assign if_instr    = out_instr_q;
    assign if_pc       = out_pc_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic, all checked each cycle
// against a queue-based model of the delivery stream.
module tb_instr_fetch;
    localparam int unsigned DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        cu_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    always #5 clk = ~clk;

    instr_fetch #(.XLEN(32), .IMEM_DEPTH(DEPTH), .RESET_PC(32'h0), .INIT_FILE("")) dut (
        .clk(clk), .rst(rst), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .cu_ready(cu_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
        .halted(halted), .fault(fault), .fetch_count(fetch_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the CU-visible stream is a queue of at most two pending words.
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;
    int          m_state;
    logic [31:0] m_pc, m_count;
    bit          m_bubble;
    logic [31:0] q_pc[$];
    logic [31:0] q_ins[$];
    logic [31:0] mm[DEPTH];

    function automatic bit bad_pc(input logic [31:0] p);
        return (p[1:0] != 2'b00) || ((p >> 2) >= DEPTH);
    endfunction

    task automatic model_step();
        if (rst) begin
            m_state = M_IDLE; m_pc = 0; m_count = 0; m_bubble = 0;
            q_pc.delete(); q_ins.delete();
        end else if (m_state == M_IDLE) begin
            m_state = M_RUN;
        end else if (m_state == M_RUN) begin
            if (q_pc.size() > 0 && cu_ready) begin
                m_count = m_count + 1;
                void'(q_pc.pop_front());
                void'(q_ins.pop_front());
            end
            if (redirect_valid) begin
                m_pc = redirect_pc; m_bubble = 1;
                q_pc.delete(); q_ins.delete();
            end else if (halt_req) begin
                m_state = M_HALT; m_bubble = 0;
                q_pc.delete(); q_ins.delete();
            end else if (m_bubble) begin
                m_bubble = 0;
            end else if (q_pc.size() < 2) begin
                if (bad_pc(m_pc)) begin
                    m_state = M_FAULT;
                    q_pc.delete(); q_ins.delete();
                end else begin
                    q_pc.push_back(m_pc);
                    q_ins.push_back(mm[m_pc[9:2]]);
                    m_pc = m_pc + 4;
                end
            end
        end
        if (imem_we) mm[imem_waddr] = imem_wdata;
    endtask

    task automatic cyc();
        bit was_rst;
        was_rst = rst;
        model_step();
        @(posedge clk);
        #1;
        check("if_valid", 32'(if_valid), 32'(q_pc.size() > 0));
        if (q_pc.size() > 0) begin
            check("if_pc", if_pc, q_pc[0]);
            check("if_instr", if_instr, q_ins[0]);
        end
        check("halted", 32'(halted), 32'(m_state == M_HALT));
        check("fault", 32'(fault), 32'(m_state == M_FAULT));
        check("fetch_count", fetch_count, m_count);
        if (was_rst) begin
            check("rst_if_pc", if_pc, 32'h0);
            check("rst_if_instr", if_instr, 32'h0);
        end
    endtask

    task automatic quiet();
        imem_we = 0; cu_ready = 0; redirect_valid = 0; redirect_pc = 0; halt_req = 0;
    endtask

    task automatic do_reset();
        quiet(); rst = 1; cyc(); rst = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        logic [31:0] bads [2];
        bads[0] = 32'h402;
        bads[1] = DEPTH * 4;
        quiet();
        rst = 1;
        // Preload while held in reset
        for (int i = 0; i < DEPTH; i++) begin
            imem_we = 1; imem_waddr = 8'(i);
            case (i)
                0: imem_wdata = 32'h11;
                1: imem_wdata = 32'h22;
                2: imem_wdata = 32'h33;
                3: imem_wdata = 32'h44;
                16: imem_wdata = 32'hAB;
                default: imem_wdata = $urandom;
            endcase
            cyc();
        end
        imem_we = 0;

        // 1: latency and streaming
        rst = 0; cu_ready = 1;
        run(2);
        check("t1_first_valid", 32'(if_valid), 32'd1);
        check("t1_first_pc", if_pc, 32'h0);
        check("t1_first_instr", if_instr, 32'h11);
        run(4);
        check("t1_count", fetch_count, 32'd4);

        // 2: stall with skid fill, then drain in order
        do_reset(); cu_ready = 1; run(3);
        cu_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t2_hold_pc", if_pc, 32'h4);
            check("t2_hold_instr", if_instr, 32'h22);
        end
        cu_ready = 1; cyc();
        check("t2_pc8", if_pc, 32'h8);
        cyc();
        check("t2_pc12", if_pc, 32'hC);
        check("t2_instr12", if_instr, 32'h44);
        check("t2_count", fetch_count, 32'd3);

        // 3: redirect while stalled with skid full
        do_reset(); cu_ready = 1; run(3);
        cu_ready = 0; run(2);
        redirect_valid = 1; redirect_pc = 32'h40; cyc();
        check("t3_squash", 32'(if_valid), 32'd0);
        redirect_valid = 0; cyc();
        check("t3_bubble", 32'(if_valid), 32'd0);
        cyc();
        check("t3_tgt_valid", 32'(if_valid), 32'd1);
        check("t3_tgt_pc", if_pc, 32'h40);
        check("t3_tgt_instr", if_instr, 32'hAB);
        cu_ready = 1; run(2);

        // 4: halt alongside a transfer; redirect ignored afterwards
        do_reset(); cu_ready = 1; run(4);
        halt_req = 1; cyc();
        check("t4_halted", 32'(halted), 32'd1);
        check("t4_count", fetch_count, 32'd3);
        halt_req = 0; redirect_valid = 1; redirect_pc = 32'h40;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t4_no_valid", 32'(if_valid), 32'd0);
        end
        redirect_valid = 0;

        // 5: misaligned and out-of-range targets
        for (int b = 0; b < 2; b++) begin
            do_reset(); cu_ready = 1; run(3);
            redirect_valid = 1; redirect_pc = bads[b]; cyc();
            redirect_valid = 0; cyc();
            check("t5_no_fault_yet", 32'(fault), 32'd0);
            cyc();
            check("t5_fault", 32'(fault), 32'd1);
            check("t5_fault_valid", 32'(if_valid), 32'd0);
            run(2);
            rst = 1; cyc(); rst = 0;
            check("t5_fault_clear", 32'(fault), 32'd0);
        end

        // 6: reset mid-stream
        do_reset(); cu_ready = 1; run(4);
        rst = 1; cyc();
        check("t6_valid", 32'(if_valid), 32'd0);
        check("t6_count", fetch_count, 32'd0);
        rst = 0; run(2);
        check("t6_restart_pc", if_pc, 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(0, 99) < 2);
            cu_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 99) < 6);
            redirect_pc    = 32'($urandom_range(0, DEPTH + 4)) * 4
                             + (($urandom_range(0, 9) == 0) ? 32'd2 : 32'd0);
            halt_req       = ($urandom_range(0, 99) < 2);
            imem_we        = ($urandom_range(0, 4) == 0);
            imem_waddr     = ($urandom_range(0, 1) == 0) ? m_pc[9:2] : 8'($urandom);
            imem_wdata     = $urandom;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
